// File: rtl/adc128s_sequencer.sv
// adc128s_sequencer: scans enabled channels of an ADC128S-style serial ADC.
// One start pulse runs one 16-bit frame: CS_L low, 16 SCLK periods, the next
// channel address shifted out on DIN bits 3..5 and 16 DOUT bits captured.
// The ADC returns the channel addressed in the previous frame, so the first
// frame after reset is a dummy whose result is discarded.
//
// Optional feature macro: ADC_SEQ_OVERRUN_EN
//   defined   -> X_Overrun is a sticky start-while-busy flag
//   undefined -> X_Overrun tied low, X_Overrun_Clear ignored
//
// Pulse semantics: X_Start_pulse and X_Sample_Valid_pulse are single-tick
// strobes with no backpressure; a start is taken only in IDLE with a nonzero
// mask, and a result is present on X_Sample_Channel/X_Sample_Word for exactly
// the tick X_Sample_Valid_pulse is high, then held until the next pulse.
module adc128s_sequencer #(
  parameter int NUM_CH  = 8,
  parameter int DATA_W  = 12,
  parameter int CLK_DIV = 4
) (
  input  logic                     X_512x96k_1024x48k_Clk,
  input  logic                     X_Reset_L,
  input  logic                     X_Start_pulse,
  input  logic [NUM_CH-1:0]        X_Ch_Enable,
  input  logic                     X_Overrun_Clear,
  input  logic                     X_ADC_SerDat_Return,
  output logic                     X_ADC_CS_L,
  output logic                     X_ADC_Clock,
  output logic                     X_ADC_SerDat_Send,
  output logic                     X_Busy,
  output logic                     X_Sample_Valid_pulse,
  output logic [2:0]               X_Sample_Channel,
  output logic [DATA_W-1:0]        X_Sample_Word,
  output logic [NUM_CH*DATA_W-1:0] X_Ch_Words,
  output logic                     X_Overrun,
  output logic [1:0]               dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FRAME = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam int PH_W = $clog2(CLK_DIV);
  localparam logic [PH_W-1:0] PH_HALF = PH_W'(CLK_DIV / 2);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(CLK_DIV - 1);

  state_t            state;
  state_t            state_nx;
  logic [PH_W-1:0]   phase;       // tick within the current SCLK period
  logic [3:0]        bit_idx;     // 0..15, bit k = bit_idx + 1
  logic [2:0]        addr;        // channel addressed in the current/last frame
  logic [2:0]        addr_nx;
  logic [2:0]        conv_ch;     // channel whose result this frame returns
  logic              dummy;       // first frame since reset carries no data
  logic [11:0]       shreg;
  logic [11:0]       shreg_nx;
  logic [DATA_W-1:0] word_nx;
  logic              accept;
  logic              frame_end;
  logic              sample_now;
  logic              unused_msb;

  assign accept     = (state == S_IDLE) && X_Start_pulse && (|X_Ch_Enable);
  assign frame_end  = (state == S_FRAME) && (bit_idx == 4'd15) && (phase == PH_LAST);
  assign sample_now = (state == S_FRAME) && (phase == PH_HALF);
  assign shreg_nx   = sample_now ? {shreg[10:0], X_ADC_SerDat_Return} : shreg;
  assign word_nx    = shreg_nx[11 -: DATA_W];
  assign unused_msb = shreg[11];

  // Next channel: lowest enabled index above addr, else lowest enabled (wrap).
  always_comb begin
    logic       found_hi;
    logic [2:0] hi;
    logic [2:0] lo;
    found_hi = 1'b0;
    hi       = '0;
    lo       = '0;
    addr_nx  = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (X_Ch_Enable[i]) begin
        lo = 3'(i);
        if (3'(i) > addr) begin
          hi       = 3'(i);
          found_hi = 1'b1;
        end
      end
    end
    addr_nx = found_hi ? hi : lo;
  end

  // State register.
  always_ff @(posedge X_512x96k_1024x48k_Clk or negedge X_Reset_L) begin
    if (!X_Reset_L) state <= S_IDLE;
    else            state <= state_nx;
  end

  // Next-state logic: FRAME runs 16*CLK_DIV ticks, DONE is a single tick.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (accept) state_nx = S_FRAME;
      S_FRAME: if (frame_end) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // SCLK phase and bit counters; parked at zero outside FRAME.
  always_ff @(posedge X_512x96k_1024x48k_Clk or negedge X_Reset_L) begin
    if (!X_Reset_L) begin
      phase   <= '0;
      bit_idx <= '0;
    end else if ((state == S_FRAME) && !frame_end) begin
      if (phase == PH_LAST) begin
        phase   <= '0;
        bit_idx <= bit_idx + 4'd1;
      end else begin
        phase <= phase + PH_W'(1);
      end
    end else begin
      phase   <= '0;
      bit_idx <= '0;
    end
  end

  // DOUT shift register, MSB first; only the last 12 bits matter.
  always_ff @(posedge X_512x96k_1024x48k_Clk or negedge X_Reset_L) begin
    if (!X_Reset_L) shreg <= '0;
    else            shreg <= shreg_nx;
  end

  // Channel bookkeeping: pick the next address when a frame is accepted.
  always_ff @(posedge X_512x96k_1024x48k_Clk or negedge X_Reset_L) begin
    if (!X_Reset_L) begin
      addr    <= '0;
      conv_ch <= '0;
      dummy   <= 1'b1;
    end else begin
      if (accept) begin
        conv_ch <= addr;
        addr    <= addr_nx;
      end
      if (state == S_DONE) dummy <= 1'b0;
    end
  end

  // Result capture on the FRAME->DONE edge so it is visible on the DONE tick.
  always_ff @(posedge X_512x96k_1024x48k_Clk or negedge X_Reset_L) begin
    if (!X_Reset_L) begin
      X_Sample_Channel <= '0;
      X_Sample_Word    <= '0;
      X_Ch_Words       <= '0;
    end else if (frame_end && !dummy) begin
      X_Sample_Channel <= conv_ch;
      X_Sample_Word    <= word_nx;
      for (int n = 0; n < NUM_CH; n++) begin
        if (conv_ch == 3'(n)) X_Ch_Words[n*DATA_W +: DATA_W] <= word_nx;
      end
    end
  end

  // DIN carries ADD2/ADD1/ADD0 on bits 3/4/5; it moves with bit_idx, i.e. on SCLK fall.
  always_comb begin
    X_ADC_SerDat_Send = 1'b0;
    if (state == S_FRAME) begin
      case (bit_idx)
        4'd2:    X_ADC_SerDat_Send = addr[2];
        4'd3:    X_ADC_SerDat_Send = addr[1];
        4'd4:    X_ADC_SerDat_Send = addr[0];
        default: X_ADC_SerDat_Send = 1'b0;
      endcase
    end
  end

  assign X_ADC_CS_L           = (state != S_FRAME);
  assign X_ADC_Clock          = (state != S_FRAME) || (phase >= PH_HALF);
  assign X_Busy               = (state == S_FRAME);
  assign X_Sample_Valid_pulse = (state == S_DONE) && !dummy;
  assign dbg_state            = state;

`ifdef ADC_SEQ_OVERRUN_EN
  logic overrun;

  // Sticky start-while-busy flag; a new start beats a clear on the same tick.
  always_ff @(posedge X_512x96k_1024x48k_Clk or negedge X_Reset_L) begin
    if (!X_Reset_L)                            overrun <= 1'b0;
    else if (X_Start_pulse && state != S_IDLE) overrun <= 1'b1;
    else if (X_Overrun_Clear)                  overrun <= 1'b0;
  end

  assign X_Overrun = overrun;
`else
  logic unused_clear;
  assign unused_clear = X_Overrun_Clear;
  assign X_Overrun    = 1'b0;
`endif

endmodule

// File: tb/tb_adc128s_sequencer.sv
// Bench for adc128s_sequencer: ADC behavioural model on the serial pins, a
// channel-address model, and a scoreboard of expected results.
module tb_adc128s_sequencer;

  localparam int NUM_CH  = 8;
  localparam int DATA_W  = 12;
  localparam int CLK_DIV = 4;
  localparam int FRAME_TICKS = 16 * CLK_DIV;
  localparam int W = 3 + DATA_W;
`ifdef ADC_SEQ_OVERRUN_EN
  localparam logic OVR_EN = 1'b1;
`else
  localparam logic OVR_EN = 1'b0;
`endif

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     start;
  logic [NUM_CH-1:0]        ch_enable;
  logic                     ovr_clear;
  logic                     adc_dout = 1'b0;
  logic                     cs_l;
  logic                     sclk;
  logic                     din;
  logic                     busy;
  logic                     valid;
  logic [2:0]               sample_ch;
  logic [DATA_W-1:0]        sample_word;
  logic [NUM_CH*DATA_W-1:0] ch_words;
  logic                     overrun;
  logic [1:0]               dbg_state;

  adc128s_sequencer #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .CLK_DIV(CLK_DIV)) dut (
    .X_512x96k_1024x48k_Clk (clk),
    .X_Reset_L              (rst_n),
    .X_Start_pulse          (start),
    .X_Ch_Enable            (ch_enable),
    .X_Overrun_Clear        (ovr_clear),
    .X_ADC_SerDat_Return    (adc_dout),
    .X_ADC_CS_L             (cs_l),
    .X_ADC_Clock            (sclk),
    .X_ADC_SerDat_Send      (din),
    .X_Busy                 (busy),
    .X_Sample_Valid_pulse   (valid),
    .X_Sample_Channel       (sample_ch),
    .X_Sample_Word          (sample_word),
    .X_Ch_Words             (ch_words),
    .X_Overrun              (overrun),
    .dbg_state              (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];       // {channel, word} per expected valid pulse
  logic [2:0]   exp_din_q[$];   // expected DIN address per frame
  logic [2:0]   tb_addr = 3'd0;
  logic         tb_dummy = 1'b1;
  logic         abort_frame = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Rotating search from cur+1: first enabled channel met.
  function automatic logic [2:0] next_addr(input logic [7:0] m, input logic [2:0] cur);
    logic [2:0] idx;
    for (int j = 1; j <= 8; j++) begin
      idx = cur + 3'(j);
      if (m[idx]) return idx;
    end
    return 3'd0;
  endfunction

  // ---------------- ADC model + frame monitor ----------------
  logic        prev_sclk = 1'b1;
  logic        prev_cs = 1'b1;
  int          cs_low_cnt = 0;
  int          adc_rises = 0;
  int          adc_bitpos = 0;
  logic [15:0] adc_word = '0;
  logic [2:0]  adc_conv_ch = 3'd0;
  logic [2:0]  adc_cap = 3'd0;
  logic [2:0]  last_ch = 3'd0;
  logic [DATA_W-1:0] last_word = '0;

  always @(negedge clk) begin
    logic [W-1:0] e;
    logic [2:0]   ea;
    int           idx;
    if (!cs_l) begin
      if (prev_cs) begin
        cs_low_cnt = 0;
        adc_rises  = 0;
        adc_bitpos = 0;
        adc_cap    = 3'd0;
        adc_word   = {4'h0, 12'hA50 | {9'd0, adc_conv_ch}};
      end
      cs_low_cnt++;
      if (prev_sclk && !sclk && adc_bitpos < 16) begin
        adc_dout = adc_word[15 - adc_bitpos];
        adc_bitpos++;
      end
      if (!prev_sclk && sclk) begin
        adc_rises++;
        if (adc_rises >= 3 && adc_rises <= 5) adc_cap = {adc_cap[1:0], din};
      end
    end else if (!prev_cs) begin
      adc_conv_ch = adc_cap;
      adc_dout    = 1'b0;
      if (abort_frame) begin
        if (exp_din_q.size() > 0) ea = exp_din_q.pop_front();
        abort_frame = 1'b0;
      end else begin
        check_val("cs_low_ticks", cs_low_cnt, FRAME_TICKS);
        check_val("sclk_pulses", adc_rises, 16);
        if (exp_din_q.size() == 0) check_val("din_unexpected_frame", 1, 0);
        else begin
          ea = exp_din_q.pop_front();
          check_val("din_addr", {29'd0, adc_cap}, {29'd0, ea});
        end
      end
    end
    prev_sclk = sclk;
    prev_cs   = cs_l;

    if (!rst_n) begin
      last_ch   = 3'd0;
      last_word = '0;
    end else if (valid) begin
      if (exp_q.size() == 0) check_val("spurious_valid", 1, 0);
      else begin
        e   = exp_q.pop_front();
        idx = int'(e[W-1 -: 3]);
        check_val("valid_ch", {29'd0, sample_ch}, {29'd0, e[W-1 -: 3]});
        check_val("valid_word", 32'(sample_word), 32'(e[DATA_W-1:0]));
        check_val("ch_words_slice", 32'(ch_words[idx*DATA_W +: DATA_W]), 32'(e[DATA_W-1:0]));
      end
      last_ch   = sample_ch;
      last_word = sample_word;
    end else begin
      check_val("hold_ch", {29'd0, sample_ch}, {29'd0, last_ch});
      check_val("hold_word", 32'(sample_word), 32'(last_word));
    end
  end

  // ---------------- driver tasks ----------------
  // Called #1 after a rising edge; the start is sampled on the next edge.
  task automatic start_frame(input logic [7:0] mask);
    logic [2:0]  nxt;
    logic [11:0] w;
    ch_enable = mask;
    start     = 1'b1;
    if (mask != 8'd0) begin
      nxt = next_addr(mask, tb_addr);
      exp_din_q.push_back(nxt);
      w = 12'hA50 | {9'd0, tb_addr};
      if (!tb_dummy) exp_q.push_back({tb_addr, w});
      tb_addr  = nxt;
      tb_dummy = 1'b0;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    check_val("cs_l_after_start", {31'd0, cs_l}, {31'd0, (mask == 8'd0)});
    check_val("busy_after_start", {31'd0, busy}, {31'd0, (mask != 8'd0)});
    // Mask changes during the frame must have no effect.
    ch_enable = 8'($urandom_range(0, 255));
  endtask

  task automatic wait_frame_end();
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
      if (!busy) done = 1'b1;
    end
    if (!done) check_val("frame_timeout", 0, 1);
    @(posedge clk);
    #1;
    check_val("pending_exp", exp_q.size(), 0);
  endtask

  task automatic run_frame(input logic [7:0] mask);
    start_frame(mask);
    wait_frame_end();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    ch_enable = '0;
    ovr_clear = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_cs_l", {31'd0, cs_l}, 1);
    check_val("rst_sclk", {31'd0, sclk}, 1);
    check_val("rst_din", {31'd0, din}, 0);
    check_val("rst_busy", {31'd0, busy}, 0);
    check_val("rst_valid", {31'd0, valid}, 0);
    check_val("rst_words_zero", {31'd0, (ch_words == '0)}, 1);
    check_val("rst_overrun", {31'd0, overrun}, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Dummy frame addressing ch1, then eight more: results 1..7, 0.
    run_frame(8'hFF);
    for (int f = 0; f < 8; f++) run_frame(8'hFF);
    for (int n = 0; n < NUM_CH; n++)
      check_val("words_after_scan", 32'(ch_words[n*DATA_W +: DATA_W]), 32'(12'hA50 | 12'(n)));

    // Sparse mask: addresses 2,7,2,7; then ch7 disabled after being addressed.
    for (int f = 0; f < 4; f++) run_frame(8'b1000_0100);
    run_frame(8'b0000_0100);

    // Start while busy; clear and start on the same tick.
    check_val("ovr_before", {31'd0, overrun}, 0);
    start_frame(8'hFF);
    repeat (8) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check_val("ovr_set", {31'd0, overrun}, {31'd0, OVR_EN});
    repeat (5) @(posedge clk);
    #1;
    start     = 1'b1;
    ovr_clear = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    ovr_clear = 1'b0;
    check_val("ovr_set_wins", {31'd0, overrun}, {31'd0, OVR_EN});
    wait_frame_end();
    ovr_clear = 1'b1;
    @(posedge clk);
    #1;
    ovr_clear = 1'b0;
    check_val("ovr_cleared", {31'd0, overrun}, 0);

    // Empty mask: the start is ignored.
    start_frame(8'h00);
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      check_val("mask0_cs_l", {31'd0, cs_l}, 1);
      check_val("mask0_busy", {31'd0, busy}, 0);
      check_val("mask0_overrun", {31'd0, overrun}, 0);
    end
    @(posedge clk);
    #1;

    // Reset at frame tick 30.
    start_frame(8'hFF);
    repeat (29) @(posedge clk);
    #1;
    abort_frame = 1'b1;
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_cs_l", {31'd0, cs_l}, 1);
    check_val("mid_rst_sclk", {31'd0, sclk}, 1);
    check_val("mid_rst_din", {31'd0, din}, 0);
    check_val("mid_rst_busy", {31'd0, busy}, 0);
    check_val("mid_rst_valid", {31'd0, valid}, 0);
    check_val("mid_rst_ch", {29'd0, sample_ch}, 0);
    check_val("mid_rst_word", 32'(sample_word), 0);
    check_val("mid_rst_words_zero", {31'd0, (ch_words == '0)}, 1);
    check_val("mid_rst_overrun", {31'd0, overrun}, 0);
    check_val("mid_rst_state", {30'd0, dbg_state}, 0);
    tb_addr  = 3'd0;
    tb_dummy = 1'b1;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_frame(8'hFF);   // dummy again, addresses ch1
    run_frame(8'hFF);   // reports ch1

    // A few random nonzero masks.
    for (int f = 0; f < 5; f++) run_frame(8'($urandom_range(1, 255)));

    check_val("exp_q_drained", exp_q.size(), 0);
    check_val("exp_din_q_drained", exp_din_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/adc128s_sequencer.md
ADC128S_SEQUENCER -- requirements
Module: adc128s_sequencer

Interface
REQ-001 SHALL have parameter NUM_CH, default 8, number of ADC input channels scanned (1..8).
REQ-002 SHALL have parameter DATA_W, default 12, conversion word width (1..12; the top DATA_W of the last 12 returned bits are kept).
REQ-003 SHALL have parameter CLK_DIV, default 4, clock ticks per SCLK period (even, >=2).
REQ-004 SHALL have port X_512x96k_1024x48k_Clk  in  1  sole clock, all logic on its rising edge.
REQ-005 SHALL have port X_Reset_L  in  1  asynchronous active-low reset.
REQ-006 SHALL have port X_Start_pulse  in  1  one-tick request for one 16-bit conversion frame.
REQ-007 SHALL have port X_Ch_Enable  in  NUM_CH  scan mask, bit n enables channel n.
REQ-008 SHALL have port X_Overrun_Clear  in  1  one-tick clear of X_Overrun.
REQ-009 SHALL have port X_ADC_SerDat_Return  in  1  ADC DOUT.
REQ-010 SHALL have ports X_ADC_CS_L, X_ADC_Clock, X_ADC_SerDat_Send  out  1 each  ADC chip select, SCLK (idle high), DIN.
REQ-011 SHALL have port X_Busy  out  1  frame in progress.
REQ-012 SHALL have ports X_Sample_Valid_pulse  out  1, X_Sample_Channel  out  3, X_Sample_Word  out  DATA_W  per-result strobe, channel and word.
REQ-013 SHALL have port X_Ch_Words  out  NUM_CH*DATA_W  last word per channel, channel n at bits [n*DATA_W +: DATA_W].
REQ-014 SHALL have port X_Overrun  out  1  sticky start-while-busy flag.

Function
REQ-015 SHALL implement states IDLE -> FRAME -> DONE -> IDLE; FRAME lasts exactly 16*CLK_DIV ticks, DONE exactly 1 tick.
REQ-016 SHALL accept X_Start_pulse only in IDLE with X_Ch_Enable nonzero; accept at tick T -> CS_L low and X_Busy high from T+1.
REQ-017 SHALL, per bit k (1..16), drive SCLK low for the first CLK_DIV/2 ticks and high for the rest; DIN changes only on SCLK falling edge.
REQ-018 SHALL sample DOUT on the tick SCLK rises and shift it in MSB-first; the last 12 bits form the result.
REQ-019 SHALL drive DIN with the next channel address ADD2/ADD1/ADD0 on bits 3/4/5, 0 on all other bits.
REQ-020 SHALL compute the next address at frame acceptance: lowest enabled index above the previously addressed channel, else the lowest enabled index (wrap); indices >= NUM_CH never addressed.
REQ-021 SHALL raise CS_L at T+1+16*CLK_DIV (entering DONE) and, on that DONE tick, pulse X_Sample_Valid_pulse with the channel converted this frame (the one addressed in the previous frame), update that channel's slice of X_Ch_Words, and drop X_Busy.
REQ-022 SHALL treat the first frame after reset as dummy: no valid pulse, no X_Ch_Words update.
REQ-023 SHALL report a converted channel even if disabled in the mask after it was addressed.
REQ-024 SHALL ignore X_Ch_Enable changes during FRAME/DONE.
REQ-025 SHALL ignore X_Start_pulse in IDLE when X_Ch_Enable is all zero (no frame, no overrun).
REQ-026 SHALL hold X_Sample_Word/X_Sample_Channel stable between valid pulses.

Reset
REQ-027 SHALL, on X_Reset_L low, immediately force IDLE, CS_L=1, SCLK=1, DIN=0, X_Busy=0, valid=0, X_Sample_Channel=0, X_Sample_Word=0, X_Ch_Words=0, X_Overrun=0, addressed channel=0, dummy flag set, including mid-frame.

Configuration
REQ-028 SHALL, with ADC_SEQ_OVERRUN_EN defined, set X_Overrun on X_Start_pulse during FRAME or DONE and clear it on X_Overrun_Clear; set wins on same tick.
REQ-029 SHALL, without ADC_SEQ_OVERRUN_EN, tie X_Overrun to 0, ignore X_Overrun_Clear, and drop start-while-busy silently.

Verification
REQ-030 SHALL cover: reset, CLK_DIV=4, mask 8'hFF, start -> CS_L low 64 ticks, 16 SCLK pulses, DIN addresses ch1, no valid pulse (dummy).
REQ-031 SHALL cover: mask 8'hFF, 9 back-to-back frames, ADC model returns 12'hA5n for ch n -> valid channels 1..7 then 0, X_Ch_Words slice n = 12'hA5n.
REQ-032 SHALL cover: mask 8'b1000_0100 -> DIN addresses 2,7,2,7; reported channels lag one frame.
REQ-033 SHALL cover: start at frame tick 10 with macro defined -> X_Overrun=1, frame length unchanged; clear and start same tick -> X_Overrun stays 1.
REQ-034 SHALL cover: X_Reset_L low at frame tick 30 -> CS_L and SCLK high same tick, all outputs 0, next frame dummy.
REQ-035 SHALL cover: mask 0 with start -> CS_L stays high, X_Busy stays 0, X_Overrun stays 0.
